wb_regfile: RTL

- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects writeback data (memory load data or ALU result), writes the 32-entry register file, and serves the two ID-stage read ports with same-cycle write bypass.
- Exposes the resolved writeback bus to the forwarding unit, and a retired-write counter for debug and bench checks.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/regfile_2r1w.sv | 68 ++++++
 rtl/wb_regfile.sv | 73 +++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants: datapath widths, the hardwired zero register
// index and the MemREG writeback-select encoding. Used by MEM/WB, writeback,
// forwarding and hazard logic.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // Index of the hardwired-zero register.
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // MemREG control bit encoding.
  typedef enum logic {
    WB_SEL_ALU = 1'b0,
    WB_SEL_MEM = 1'b1
  } wb_sel_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file. Entry 0 is never written and always
// reads zero. Reads are combinational, and a read of the index being written
// this cycle returns the write data (write-through bypass).
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  // A write to index 0 is ignored so entry 0 stays at its reset value of zero.
  logic write_ok;
  assign write_ok = we && (waddr != '0);

  // Next array contents: unchanged except for the single written entry.
  always_comb begin
    regs_d = regs_q;
    if (write_ok) begin
      regs_d[waddr] = wdata;
    end
  end

  // Array update; reset clears every entry and drops any write in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Both read ports share the same rules, so they are built from one template:
  // index 0 reads zero, a match on the in-flight write bypasses, else the array.
  logic [1:0][ADDR_W-1:0] raddr;
  logic [1:0][DATA_W-1:0] rdata;

  assign raddr = {rb_addr, ra_addr};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      assign rdata[gi] = (raddr[gi] == '0)                  ? '0 :
                         (write_ok && (raddr[gi] == waddr)) ? wdata :
                                                              regs_q[raddr[gi]];
    end
  endgenerate

  assign ra_data = rdata[0];
  assign rb_data = rdata[1];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: picks load data or ALU result, writes it into the register
// file, serves the ID-stage read ports, publishes the resolved writeback to
// the forwarding unit and counts retired register writes.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_memreg,
  input  logic              in_regwrite,
  input  logic [DATA_W-1:0] in_datmem,
  input  logic [DATA_W-1:0] in_aluresult,
  input  logic [ADDR_W-1:0] in_wreg,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_wreg,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  wr_count
);

  wb_sel_e wb_sel;
  logic [CNT_W-1:0] wr_count_q;
  logic [CNT_W-1:0] wr_count_d;

  // Resolved writeback: a write to index 0 is not a real write anywhere,
  // so the forwarding unit never sees it as a producer.
  assign wb_sel  = wb_sel_e'(in_memreg);
  assign wb_data = (wb_sel == WB_SEL_MEM) ? in_datmem : in_aluresult;
  assign wb_we   = in_regwrite && (in_wreg != '0);
  assign wb_wreg = in_wreg;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_we),
    .waddr   (in_wreg),
    .wdata   (wb_data),
    .ra_addr (rs_addr),
    .rb_addr (rt_addr),
    .ra_data (rs_data),
    .rb_data (rt_data)
  );

  // Retired-write count: one per effective write, wrapping naturally.
  always_comb begin
    wr_count_d = wr_count_q;
    if (wb_we) begin
      wr_count_d = wr_count_q + 1'b1;
    end
  end

  // Counter register; reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;

endmodule
